multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port i_clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port i_op, input, 7: opcode from the instruction register; stable from DECODE until the next FETCH.
REQ-005 SHALL have port i_zero, input, 1: ALU zero flag.
REQ-006 SHALL have port i_mem_ready, input, 1: memory completes the current request this cycle.
REQ-007 SHALL have port o_immsrc, output, 2: immediate-extender select (00 I, 01 S, 10 B, 11 J).
REQ-008 SHALL have ports o_alusrca (2: 00 PC, 01 oldPC, 10 rs1), o_alusrcb (2: 00 rs2, 01 imm, 10 const 4), o_aluop (2: 00 add, 01 sub, 10 funct-decode), o_resultsrc (2: 00 ALUOut, 01 data, 10 ALUResult), all outputs.
REQ-009 SHALL have 1-bit outputs o_adrsrc (0 PC, 1 ALUOut), o_mem_req, o_irwrite, o_pcwrite, o_regwrite, o_memwrite.
REQ-010 SHALL have port o_state, output, 4: current state encoding, for debug.
REQ-011 SHALL have port o_instret, output, CNT_W: retired-instruction count.
REQ-012 SHALL have port o_illegal, output, 1: sticky illegal-opcode flag.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11; outputs Moore except where a state's outputs depend on i_mem_ready or i_zero; every output not listed for a state is 0.
REQ-014 SHALL in FETCH drive o_mem_req=1, o_alusrcb=10, o_resultsrc=10, o_irwrite=o_pcwrite=i_mem_ready; remain in FETCH while i_mem_ready=0, else go to DECODE.
REQ-015 SHALL in DECODE drive o_alusrca=01, o_alusrcb=01, o_immsrc=10; next state by i_op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, other -> per REQ-027/028.
REQ-016 SHALL in MEMADR drive o_alusrca=10, o_alusrcb=01, o_immsrc=00 for lw and 01 for sw; next state MEMREAD (lw) or MEMWRITE (sw).
REQ-017 SHALL in MEMREAD drive o_adrsrc=1, o_mem_req=1; hold until i_mem_ready=1, then go to MEMWB.
REQ-018 SHALL in MEMWB drive o_resultsrc=01, o_regwrite=1; next state FETCH.
REQ-019 SHALL in MEMWRITE drive o_adrsrc=1, o_mem_req=1, o_memwrite=1; hold until i_mem_ready=1, then go to FETCH.
REQ-020 SHALL in EXECR drive o_alusrca=10, o_alusrcb=00, o_aluop=10; in EXECI the same with o_alusrcb=01, o_immsrc=00; both go to ALUWB.
REQ-021 SHALL in ALUWB drive o_regwrite=1 with o_resultsrc=00; next state FETCH.
REQ-022 SHALL in BEQ drive o_alusrca=10, o_aluop=01, o_pcwrite=i_zero; next state FETCH.
REQ-023 SHALL in JAL drive o_alusrca=01, o_alusrcb=10, o_immsrc=11, o_pcwrite=1; next state ALUWB.
REQ-024 SHALL increment o_instret by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; never on a FETCH or MEMREAD/MEMWRITE stall cycle; wraps from 2^CNT_W-1 to 0.
REQ-025 SHALL have cycle counts lw 5, sw 4, R/I 4, beq 3, jal 4, each plus wait cycles while i_mem_ready=0.

Reset
REQ-026 SHALL when i_rst_n=0 at a rising edge, regardless of state or pending memory request, go to FETCH, clear o_instret and o_illegal; reset has priority over all transitions; all outputs follow FETCH decode on the next cycle.

Configuration
REQ-027 SHALL with macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined, on an unsupported opcode in DECODE go to ILLEGAL, set o_illegal=1, drive all enables 0, and stay there until reset.
REQ-028 SHALL without MULTICYCLE_CTRL_ILLEGAL_TRAP_EN, on an unsupported opcode return from DECODE to FETCH without incrementing o_instret; o_illegal is tied 0 and ILLEGAL is unreachable.

Verification
REQ-029 SHALL cover: reset, then lw (i_op=0000011), i_mem_ready=1 always -> states 0,1,2,3,4,0 and o_instret=1.
REQ-030 SHALL cover: sw with i_mem_ready low 3 cycles in MEMWRITE -> o_memwrite=1 for 4 cycles, one write completes, o_instret increments once.
REQ-031 SHALL cover: beq with i_zero=1 then i_zero=0 -> o_pcwrite=1 in BEQ only for the first; both take 3 cycles.
REQ-032 SHALL cover: jal -> o_immsrc=11 in JAL, o_regwrite=1 in ALUWB, 4 cycles total.
REQ-033 SHALL cover: opcode 1111111 -> with the macro, o_state=11, o_illegal=1 until reset; without it, back to FETCH with o_instret unchanged.
REQ-034 SHALL cover: CNT_W=4 with 16 retired R-type instructions -> o_instret wraps to 0; a reset asserted in MEMREAD -> FETCH next cycle with o_instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V core (lw/sw/R/I/beq/jal) with a retired-instruction counter.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ILLEGAL state.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [6:0]       i_op,
   input  logic             i_zero,
   input  logic             i_mem_ready,
   output logic [1:0]       o_immsrc,
   output logic [1:0]       o_alusrca,
   output logic [1:0]       o_alusrcb,
   output logic [1:0]       o_aluop,
   output logic [1:0]       o_resultsrc,
   output logic             o_adrsrc,
   output logic             o_mem_req,
   output logic             o_irwrite,
   output logic             o_pcwrite,
   output logic             o_regwrite,
   output logic             o_memwrite,
   output logic [3:0]       o_state,
   output logic [CNT_W-1:0] o_instret,
   output logic             o_illegal
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
      EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ILLEGAL = 4'd11
   } state_t;
   typedef struct packed {
      logic [1:0] immsrc, alusrca, alusrcb, aluop, resultsrc;
      logic       adrsrc, mem_req, memwrite, regwrite, irw, pcw, br;
   } ctl_t;
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   localparam state_t BAD_OP = ILLEGAL;
   logic illegal;
   assign o_illegal = illegal;
`else
   localparam state_t BAD_OP = FETCH;
   assign o_illegal = 1'b0;
`endif
   state_t state, nxt;
   ctl_t ctl;
   logic retire;
   logic [CNT_W-1:0] instret;

   // Moore part of the decode; irw also gates the FETCH pc write, br gates the branch pc write
   function automatic ctl_t ctl_of(input state_t s, input logic [6:0] op);
      ctl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.mem_req = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.irw = 1'b1; end
         DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; c.immsrc = 2'b10; end
         MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.immsrc = (op == OP_SW) ? 2'b01 : 2'b00; end
         MEMREAD:  begin c.adrsrc = 1'b1; c.mem_req = 1'b1; end
         MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
         MEMWRITE: begin c.adrsrc = 1'b1; c.mem_req = 1'b1; c.memwrite = 1'b1; end
         EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
         EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
         ALUWB:    c.regwrite = 1'b1;
         BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.br = 1'b1; end
         JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.immsrc = 2'b11; c.pcw = 1'b1; end
         default:  ;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt = state;
      case (state)
         FETCH:    nxt = i_mem_ready ? DECODE : FETCH;
         DECODE:   nxt = (i_op == OP_LW || i_op == OP_SW) ? MEMADR :
                         (i_op == OP_R)   ? EXECR :
                         (i_op == OP_I)   ? EXECI :
                         (i_op == OP_BEQ) ? BEQ :
                         (i_op == OP_JAL) ? JAL : BAD_OP;
         MEMADR:   nxt = (i_op == OP_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  nxt = i_mem_ready ? MEMWB : MEMREAD;
         MEMWRITE: nxt = i_mem_ready ? FETCH : MEMWRITE;
         MEMWB, ALUWB, BEQ: nxt = FETCH;
         EXECR, EXECI, JAL: nxt = ALUWB;
         ILLEGAL:  nxt = ILLEGAL;
         default:  nxt = FETCH;
      endcase
   end

   assign retire = (nxt == FETCH) &&
                   (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= FETCH;
         ctl     <= ctl_of(FETCH, i_op);
         instret <= '0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         state   <= nxt;
         ctl     <= ctl_of(nxt, i_op);
         instret <= instret + CNT_W'(retire);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         illegal <= illegal | (nxt == ILLEGAL);
`endif
      end
   end

   assign o_immsrc    = ctl.immsrc;
   assign o_alusrca   = ctl.alusrca;
   assign o_alusrcb   = ctl.alusrcb;
   assign o_aluop     = ctl.aluop;
   assign o_resultsrc = ctl.resultsrc;
   assign o_adrsrc    = ctl.adrsrc;
   assign o_mem_req   = ctl.mem_req;
   assign o_memwrite  = ctl.memwrite;
   assign o_regwrite  = ctl.regwrite;
   assign o_irwrite   = ctl.irw & i_mem_ready;
   assign o_pcwrite   = ctl.pcw | (ctl.irw & i_mem_ready) | (ctl.br & i_zero);
   assign o_state     = state;
   assign o_instret   = instret;
endmodule
